// File: rtl/line_buffer3x3_1bit_pkg.sv
// Shared defaults for the 3x3 window line buffer: sample width and image row length.
package line_buffer3x3_1bit_pkg;

  localparam int DATA_WIDTH_DEFAULT  = 1;
  localparam int ROW_WIDTH_DEFAULT   = 9;
  localparam int NUM_TAPS_SUPPORTED  = 2;

endpackage : line_buffer3x3_1bit_pkg

// File: rtl/line_buffer3x3_1bit_shift_row.sv
// One image row of delay: LENGTH enable-gated register stages, output taken from the last stage.
module shift_row
  import line_buffer3x3_1bit_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int LENGTH     = ROW_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  // Stage 0 receives din; stage LENGTH-1 is the row-delayed sample.
  logic [DATA_WIDTH-1:0] r_stage [LENGTH] = '{default: '0};

  // Shift chain: synchronous clear, advance only on enabled edges, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < LENGTH; k++) begin
        r_stage[k] <= '0;
      end
    end else if (en) begin
      r_stage[0] <= din;
      for (int k = 1; k < LENGTH; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end else begin
      for (int k = 0; k < LENGTH; k++) begin
        r_stage[k] <= r_stage[k];
      end
    end
  end

  assign dout = r_stage[LENGTH-1];

endmodule : shift_row

// File: rtl/line_buffer3x3_1bit.sv
// Two-row line buffer for a 3x3 window: taps one and two rows behind the incoming sample.
module line_buffer3x3_1bit
  import line_buffer3x3_1bit_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEFAULT,
  parameter int TAP_DISTANCE = ROW_WIDTH_DEFAULT,
  parameter int NUM_TAPS     = NUM_TAPS_SUPPORTED
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clken,
  input  logic [DATA_WIDTH-1:0] shiftin,
  output logic [DATA_WIDTH-1:0] taps0x,
  output logic [DATA_WIDTH-1:0] taps1x,
  output logic [DATA_WIDTH-1:0] shiftout
);

  generate
    if (NUM_TAPS != NUM_TAPS_SUPPORTED) begin : g_bad_taps
      $error("line_buffer3x3_1bit supports NUM_TAPS == 2 only");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] w_row0_out;
  logic [DATA_WIDTH-1:0] w_row1_out;

  shift_row #(
    .DATA_WIDTH (DATA_WIDTH),
    .LENGTH     (TAP_DISTANCE)
  ) u_row0 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (clken),
    .din   (shiftin),
    .dout  (w_row0_out)
  );

  // Second row is fed from the first row's tap so the two taps stay column-aligned.
  shift_row #(
    .DATA_WIDTH (DATA_WIDTH),
    .LENGTH     (TAP_DISTANCE)
  ) u_row1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (clken),
    .din   (w_row0_out),
    .dout  (w_row1_out)
  );

  assign taps0x   = w_row0_out;
  assign taps1x   = w_row1_out;
  assign shiftout = w_row1_out;

endmodule : line_buffer3x3_1bit

// File: tb/tb_line_buffer3x3_1bit.sv
// Directed and reference-model checks for line_buffer3x3_1bit (row length 9).
module tb_line_buffer3x3_1bit;

  logic clk = 1'b0;
  logic rst_n;
  logic clken;
  logic shiftin;
  logic taps0x;
  logic taps1x;
  logic shiftout;

  int n_pass  = 0;
  int n_total = 0;

  line_buffer3x3_1bit #(
    .DATA_WIDTH   (1),
    .TAP_DISTANCE (9),
    .NUM_TAPS     (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clken    (clken),
    .shiftin  (shiftin),
    .taps0x   (taps0x),
    .taps1x   (taps1x),
    .shiftout (shiftout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic observed, input logic expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s observed=%b expected=%b at %0t", tag, observed, expected, $time);
  endtask

  // Drive inputs at the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic rst_v, input logic en_v, input logic d_v);
    @(negedge clk);
    rst_n   = rst_v;
    clken   = en_v;
    shiftin = d_v;
    @(posedge clk);
    #1;
  endtask

  logic pat [27];
  logic q [$];
  logic exp0, exp1;
  int   cnt;

  initial begin
    rst_n = 1'b1; clken = 1'b0; shiftin = 1'b0;
    #1;
    check("powerup_taps0x", taps0x, 1'b0);
    check("powerup_taps1x", taps1x, 1'b0);

    // Reset
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("reset_taps0x", taps0x, 1'b0);
    check("reset_taps1x", taps1x, 1'b0);
    check("reset_shiftout", shiftout, 1'b0);

    // Impulse with continuous enable
    for (int e = 1; e <= 22; e++) begin
      step(1'b1, 1'b1, (e == 1) ? 1'b1 : 1'b0);
      check("impulse_taps0x", taps0x, (e == 9) ? 1'b1 : 1'b0);
      check("impulse_taps1x", taps1x, (e == 18) ? 1'b1 : 1'b0);
      check("impulse_shiftout", shiftout, (e == 18) ? 1'b1 : 1'b0);
    end

    // Impulse with enable low every other cycle
    step(1'b0, 1'b0, 1'b0);
    cnt = 0;
    for (int c = 0; c < 44; c++) begin
      if (c % 2 == 0) begin
        step(1'b1, 1'b1, (cnt == 0) ? 1'b1 : 1'b0);
        cnt++;
      end else begin
        step(1'b1, 1'b0, 1'b1);
      end
      check("gap_taps0x", taps0x, (cnt == 9) ? 1'b1 : 1'b0);
      check("gap_taps1x", taps1x, (cnt == 18) ? 1'b1 : 1'b0);
    end

    // Row pattern: ones at samples 0, 4 and 8
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 27; i++) pat[i] = (i == 0 || i == 4 || i == 8) ? 1'b1 : 1'b0;
    for (int i = 0; i < 27; i++) begin
      step(1'b1, 1'b1, pat[i]);
      check("row_taps0x", taps0x, (i >= 8) ? pat[i-8] : 1'b0);
      check("row_taps1x", taps1x, (i >= 17) ? pat[i-17] : 1'b0);
      if (i == 17) begin
        check("row17_taps0x_eq_s9", taps0x, 1'b0);
        check("row17_taps1x_eq_s0", taps1x, 1'b1);
      end
    end

    // Mid-stream reset after filling with ones
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1);
    check("full_taps0x", taps0x, 1'b1);
    check("full_taps1x", taps1x, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("midrst_taps0x", taps0x, 1'b0);
    check("midrst_taps1x", taps1x, 1'b0);
    for (int k = 1; k <= 19; k++) begin
      step(1'b1, 1'b1, 1'b1);
      check("refill_taps0x", taps0x, (k >= 9) ? 1'b1 : 1'b0);
      check("refill_taps1x", taps1x, (k >= 18) ? 1'b1 : 1'b0);
    end

    // Random stimulus against an ideal enabled-edge delay line
    step(1'b0, 1'b0, 1'b0);
    q = {};
    for (int c = 0; c < 1000; c++) begin
      logic en_r, d_r;
      en_r = 1'($urandom_range(0, 1));
      d_r  = 1'($urandom_range(0, 1));
      step(1'b1, en_r, d_r);
      if (en_r) begin
        q.push_front(d_r);
        if (q.size() > 18) void'(q.pop_back());
      end
      exp0 = (q.size() >= 9)  ? q[8]  : 1'b0;
      exp1 = (q.size() >= 18) ? q[17] : 1'b0;
      check("rand_taps0x", taps0x, exp0);
      check("rand_taps1x", taps1x, exp1);
      check("rand_shiftout", shiftout, exp1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_line_buffer3x3_1bit
